// File: rtl/brq_pkg.sv
// Shared types and helpers for the branch resolve queue: the in-flight
// prediction record, the default sequential PC step and pointer sizing.
package brq_pkg;

  localparam int BRQ_PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        hit;
  } brq_entry_t;

  function automatic int brq_ptr_w(input int depth);
    if (depth > 32'd1) begin
      return $clog2(depth);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-facing bundle of the branch resolve unit: fetch-side prediction
// records, EX resolution, predictor training, flush/redirect and queue status.
interface branch_resolve_unit_if #(parameter int DEPTH = 4);
  import brq_pkg::*;

  localparam int CW = brq_ptr_w(DEPTH) + 1;

  logic          stall;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic [31:0]   pred_target;
  logic          pred_hit;
  logic          ex_valid;
  logic          ex_is_branch;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic [31:0]   ex_inst;
  logic          upd_valid;
  logic          upd_direction;
  logic [31:0]   upd_pc_actual;
  logic [31:0]   upd_pc_alu;
  logic [31:0]   upd_inst;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output stall, pred_valid, pred_pc, pred_target, pred_hit,
           ex_valid, ex_is_branch, ex_taken, ex_target, ex_inst,
    input  upd_valid, upd_direction, upd_pc_actual, upd_pc_alu, upd_inst,
           flush, redirect_pc, full, empty, count, overflow
  );

  modport slave (
    input  stall, pred_valid, pred_pc, pred_target, pred_hit,
           ex_valid, ex_is_branch, ex_taken, ex_target, ex_inst,
    output upd_valid, upd_direction, upd_pc_actual, upd_pc_alu, upd_inst,
           flush, redirect_pc, full, empty, count, overflow
  );

endinterface

// File: rtl/brq_fifo.sv
// Ring buffer holding in-flight prediction records. The head entry is read
// combinationally; clear empties the queue and wins over a same-cycle push.
module brq_fifo import brq_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int PW    = brq_ptr_w(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  brq_entry_t    wr_entry,
  output brq_entry_t    rd_entry,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  brq_entry_t    mem_q [DEPTH];
  brq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  // Next-state for storage, pointers, occupancy and registered status flags.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push) begin
        mem_d[tail_q] = wr_entry;
        tail_d        = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == {CW{1'b0}});
  end

  // State registers with asynchronous reset to an empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign rd_entry = mem_q[head_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches each EX resolution against the oldest queued prediction, trains the
// predictor, and flushes/redirects the pipeline on a mispredict.
module branch_resolve_unit import brq_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int PC_STEP = BRQ_PC_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  localparam int CW = brq_ptr_w(DEPTH) + 1;

  brq_entry_t    wr_entry_s, head_entry_s;
  logic          push_s, pop_s, mispredict_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [31:0]   actual_next_s;

  logic          upd_valid_d, upd_valid_q;
  logic          upd_direction_d, upd_direction_q;
  logic [31:0]   upd_pc_actual_d, upd_pc_actual_q;
  logic [31:0]   upd_pc_alu_d, upd_pc_alu_q;
  logic [31:0]   upd_inst_d, upd_inst_q;
  logic          flush_d, flush_q;
  logic [31:0]   redirect_pc_d, redirect_pc_q;
  logic          overflow_d, overflow_q;

  assign pop_s         = bus.ex_valid & ~bus.stall & ~fifo_empty_s;
  assign push_s        = bus.pred_valid & ~bus.stall & (~fifo_full_s | pop_s);
  assign actual_next_s = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target
                                                           : head_entry_s.pc + 32'(PC_STEP);
  assign mispredict_s  = pop_s & (actual_next_s != head_entry_s.target);
  assign wr_entry_s    = '{pc: bus.pred_pc, target: bus.pred_target, hit: bus.pred_hit};

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .clear    (mispredict_s),
    .wr_entry (wr_entry_s),
    .rd_entry (head_entry_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Strobes are single-cycle; data outputs hold until the next qualifying pop.
  always_comb begin
    upd_valid_d     = 1'b0;
    flush_d         = 1'b0;
    upd_direction_d = upd_direction_q;
    upd_pc_actual_d = upd_pc_actual_q;
    upd_pc_alu_d    = upd_pc_alu_q;
    upd_inst_d      = upd_inst_q;
    redirect_pc_d   = redirect_pc_q;
    overflow_d      = overflow_q | (bus.pred_valid & ~bus.stall & fifo_full_s & ~pop_s);
    if (pop_s) begin
      upd_valid_d     = bus.ex_is_branch | head_entry_s.hit;
      upd_direction_d = bus.ex_is_branch & bus.ex_taken;
      upd_pc_actual_d = head_entry_s.pc;
      upd_pc_alu_d    = bus.ex_target;
      upd_inst_d      = bus.ex_inst;
      if (mispredict_s) begin
        flush_d       = 1'b1;
        redirect_pc_d = actual_next_s;
      end else begin
        flush_d = 1'b0;
      end
    end else begin
      upd_valid_d = 1'b0;
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q     <= 1'b0;
      upd_direction_q <= 1'b0;
      upd_pc_actual_q <= 32'h0000_0000;
      upd_pc_alu_q    <= 32'h0000_0000;
      upd_inst_q      <= 32'h0000_0000;
      flush_q         <= 1'b0;
      redirect_pc_q   <= 32'h0000_0000;
      overflow_q      <= 1'b0;
    end else begin
      upd_valid_q     <= upd_valid_d;
      upd_direction_q <= upd_direction_d;
      upd_pc_actual_q <= upd_pc_actual_d;
      upd_pc_alu_q    <= upd_pc_alu_d;
      upd_inst_q      <= upd_inst_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_direction = upd_direction_q;
  assign bus.upd_pc_actual = upd_pc_actual_q;
  assign bus.upd_pc_alu    = upd_pc_alu_q;
  assign bus.upd_inst      = upd_inst_q;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.full          = fifo_full_s;
  assign bus.empty         = fifo_empty_s;
  assign bus.count         = fifo_count_s;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a queue-based
// reference model of in-flight predictions.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] STEP = 32'd4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          hit;
  } ment_t;

  logic clk;
  logic rst;
  branch_resolve_unit_if #(.DEPTH(DEPTH)) bus();

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_STEP(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  ment_t       mq[$];
  bit          m_uv, m_dir, m_flush, m_ovf;
  logic [31:0] m_pc_act, m_pc_alu, m_inst, m_redir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_uv = 1'b0; m_dir = 1'b0; m_flush = 1'b0; m_ovf = 1'b0;
    m_pc_act = 32'h0; m_pc_alu = 32'h0; m_inst = 32'h0; m_redir = 32'h0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":upd_valid"},     bus.upd_valid,     m_uv);
    chk({ph, ":upd_direction"}, bus.upd_direction, m_dir);
    chk({ph, ":upd_pc_actual"}, bus.upd_pc_actual, m_pc_act);
    chk({ph, ":upd_pc_alu"},    bus.upd_pc_alu,    m_pc_alu);
    chk({ph, ":upd_inst"},      bus.upd_inst,      m_inst);
    chk({ph, ":flush"},         bus.flush,         m_flush);
    chk({ph, ":redirect_pc"},   bus.redirect_pc,   m_redir);
    chk({ph, ":count"},         bus.count,         mq.size());
    chk({ph, ":full"},          bus.full,          (mq.size() == DEPTH));
    chk({ph, ":empty"},         bus.empty,         (mq.size() == 0));
    chk({ph, ":overflow"},      bus.overflow,      m_ovf);
  endtask

  // Apply current inputs for one clock, advance the model, compare after the edge.
  task automatic tick(input string ph);
    bit          do_pop, do_push, misp;
    ment_t       e;
    logic [31:0] nxt;
    int          n;
    n       = mq.size();
    misp    = 1'b0;
    do_pop  = bus.ex_valid && !bus.stall && (n > 0);
    do_push = bus.pred_valid && !bus.stall && ((n < DEPTH) || do_pop);
    if (bus.pred_valid && !bus.stall && (n == DEPTH) && !do_pop) m_ovf = 1'b1;
    m_uv    = 1'b0;
    m_flush = 1'b0;
    if (do_pop) begin
      e        = mq.pop_front();
      nxt      = (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target : e.pc + STEP;
      misp     = (nxt != e.tgt);
      m_uv     = bus.ex_is_branch || e.hit;
      m_dir    = bus.ex_is_branch && bus.ex_taken;
      m_pc_act = e.pc;
      m_pc_alu = bus.ex_target;
      m_inst   = bus.ex_inst;
      if (misp) begin
        m_flush = 1'b1;
        m_redir = nxt;
        mq.delete();
      end
    end
    if (do_push && !misp) mq.push_back('{pc: bus.pred_pc, tgt: bus.pred_target, hit: bus.pred_hit});
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic drive(input bit pv, input logic [31:0] pc, input logic [31:0] tgt, input bit hit,
                       input bit ev, input bit br, input bit tk, input logic [31:0] et,
                       input logic [31:0] inst, input bit st);
    bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_target = tgt; bus.pred_hit = hit;
    bus.ex_valid = ev; bus.ex_is_branch = br; bus.ex_taken = tk; bus.ex_target = et;
    bus.ex_inst = inst; bus.stall = st;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [31:0] tgt, input bit hit, input string ph);
    drive(1'b1, pc, tgt, hit, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(ph);
  endtask

  task automatic do_pop(input bit br, input bit tk, input logic [31:0] et, input logic [31:0] inst, input string ph);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, br, tk, et, inst, 1'b0);
    tick(ph);
  endtask

  task automatic do_idle(input string ph);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(ph);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Correctly predicted sequential instruction, no training.
    do_push(32'h10, 32'h14, 1'b0, "r41_push");
    do_pop(1'b0, 1'b0, 32'h0, 32'h13, "r41_pop");
    chk("r41_upd_valid", bus.upd_valid, 32'd0);
    chk("r41_flush", bus.flush, 32'd0);
    chk("r41_empty", bus.empty, 32'd1);

    // Correctly predicted taken branch trains the predictor.
    do_push(32'h20, 32'h40, 1'b1, "r42_push");
    do_pop(1'b1, 1'b1, 32'h40, 32'h0000_0063, "r42_pop");
    chk("r42_upd_valid", bus.upd_valid, 32'd1);
    chk("r42_dir", bus.upd_direction, 32'd1);
    chk("r42_pc_actual", bus.upd_pc_actual, 32'h20);
    chk("r42_flush", bus.flush, 32'd0);

    // Mispredicted taken branch flushes the whole queue.
    do_push(32'h30, 32'h34, 1'b0, "r43_push0");
    do_push(32'h34, 32'h38, 1'b0, "r43_push1");
    do_push(32'h38, 32'h3c, 1'b0, "r43_push2");
    drive(1'b1, 32'h3c, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h0000_0463, 1'b0);
    tick("r43_pop");
    chk("r43_flush", bus.flush, 32'd1);
    chk("r43_redirect", bus.redirect_pc, 32'h80);
    chk("r43_count", bus.count, 32'd0);
    do_idle("r43_after");
    chk("r43_flush_drop", bus.flush, 32'd0);

    // Full queue with simultaneous push and pop, then a stalled cycle.
    for (int i = 0; i < 4; i++) do_push(32'h200 + 32'(i) * 4, 32'h204 + 32'(i) * 4, 1'b1, "r45_fill");
    chk("r45_full", bus.full, 32'd1);
    drive(1'b1, 32'h210, 32'h214, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013, 1'b0);
    tick("r45_pushpop");
    chk("r45_count", bus.count, 32'd4);
    chk("r45_no_ovf", bus.overflow, 32'd0);
    chk("r45_upd_valid", bus.upd_valid, 32'd1);
    drive(1'b1, 32'h214, 32'h218, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick("r45_stall");
    chk("r45_stall_count", bus.count, 32'd4);
    chk("r45_stall_upd_valid", bus.upd_valid, 32'd0);
    chk("r45_stall_pc_hold", bus.upd_pc_actual, 32'h200);
    for (int i = 0; i < 4; i++) do_pop(1'b0, 1'b0, 32'h0, 32'h13, "r45_drain");

    // Overflow on a fifth push; pops return entries in order with head wrap.
    for (int i = 0; i < 5; i++) do_push(32'h300 + 32'(i) * 4, 32'h304 + 32'(i) * 4, 1'b0, "r44_push");
    chk("r44_full", bus.full, 32'd1);
    chk("r44_ovf", bus.overflow, 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_pop(1'b0, 1'b0, 32'h0, 32'h13, "r44_pop");
      chk("r44_order", bus.upd_pc_actual, 32'h300 + 32'(i) * 4);
    end
    chk("r44_empty", bus.empty, 32'd1);

    // Asynchronous reset mid-cycle with two entries queued.
    for (int i = 0; i < 3; i++) do_push(32'h400 + 32'(i) * 4, 32'h404 + 32'(i) * 4, 1'b1, "r46_push");
    do_pop(1'b0, 1'b0, 32'h77, 32'h13, "r46_pop");
    #2;
    rst = 1'b1;
    #1;
    chk("r46_upd_valid", bus.upd_valid, 32'd0);
    chk("r46_pc_actual", bus.upd_pc_actual, 32'd0);
    chk("r46_empty", bus.empty, 32'd1);
    chk("r46_overflow", bus.overflow, 32'd0);
    model_reset();
    check_all("r46_async");
    #2;
    rst = 1'b0;
    do_push(32'h500, 32'h504, 1'b0, "r46_first_push");
    chk("r46_count1", bus.count, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, tgt, et;
      pc  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      tgt = ($urandom_range(0, 1) == 0) ? pc + STEP : 32'h2000;
      et  = ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'($urandom);
      drive($urandom_range(0, 2) != 0, pc, tgt, 1'($urandom_range(0, 1)),
            $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            et, 32'($urandom), $urandom_range(0, 5) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
